// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: mode codes and speed-select range.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_RUN_L = 2'd1,
        MODE_RUN_R = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    localparam int unsigned SPEED_W   = 2;
    localparam int unsigned SPEED_MAX = 3;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a step strobe every ((BASE_CNT+1) << speed) enabled cycles.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned BASE_CNT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [SPEED_W-1:0] speed,
    output logic               step
);

    localparam int unsigned CNT_W = $clog2((BASE_CNT + 1) << SPEED_MAX);
    localparam logic [CNT_W-1:0] BASE_P1 = CNT_W'(BASE_CNT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_term;
    logic             w_at_term;

    // The slowest period may equal 2**CNT_W; the wrap of the shift then yields an all-ones term.
    always_comb begin
        w_term    = (BASE_P1 << speed) - CNT_W'(1);
        w_at_term = (r_cnt >= w_term);
    end

    assign step = en && w_at_term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_at_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: mode FSM plus pattern register, stepped by the prescaled tick.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BASE_CNT = CLK_FREQ / 8 - 1,
    parameter int unsigned NUM_LED  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode_next,
    input  logic [SPEED_W-1:0] speed,
    output logic [NUM_LED-1:0] led,
    output logic [1:0]         mode,
    output logic               tick
);

    logic               w_step;
    mode_t              r_mode;
    mode_t              w_mode_nxt;
    mode_t              w_mode_inc;
    logic [NUM_LED-1:0] r_led;
    logic [NUM_LED-1:0] w_led_nxt;
    logic               r_tick;
    logic               w_tick_nxt;

    led_tick_gen #(
        .BASE_CNT (BASE_CNT)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (mode_next),
        .speed (speed),
        .step  (w_step)
    );

    function automatic logic [NUM_LED-1:0] entry_pattern(input mode_t m);
        case (m)
            MODE_RUN_L: return NUM_LED'(1);
            MODE_RUN_R: return {1'b1, {(NUM_LED-1){1'b0}}};
            MODE_BLINK: return '1;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [NUM_LED-1:0] advance(input mode_t m, input logic [NUM_LED-1:0] p);
        case (m)
            MODE_RUN_L: return {p[NUM_LED-2:0], p[NUM_LED-1]};
            MODE_RUN_R: return {p[0], p[NUM_LED-1:1]};
            MODE_BLINK: return ~p;
            default:    return '0;
        endcase
    endfunction

    // A mode change takes priority over a coincident step; the step is dropped.
    always_comb begin
        w_mode_inc = mode_t'(2'(r_mode + 2'd1));
        w_mode_nxt = r_mode;
        w_led_nxt  = r_led;
        w_tick_nxt = 1'b0;
        if (mode_next) begin
            w_mode_nxt = w_mode_inc;
            w_led_nxt  = entry_pattern(w_mode_inc);
        end else if (w_step) begin
            w_tick_nxt = 1'b1;
            w_led_nxt  = advance(r_mode, r_led);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode <= MODE_OFF;
            r_led  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_led  <= w_led_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    assign led  = r_led;
    assign mode = r_mode;
    assign tick = r_tick;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios then random stimulus vs. a behavioural model.
module tb_led_seq_ctrl;

    localparam int unsigned BASE_CNT = 3;
    localparam int unsigned NUM_LED  = 4;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic                mode_next;
    logic [1:0]          speed;
    logic [NUM_LED-1:0]  led;
    logic [1:0]          mode;
    logic                tick;

    int checks;
    int errors;

    // behavioural model state
    int m_cnt;
    int m_mode;
    int m_pos;
    bit m_on;
    bit m_tick;

    led_seq_ctrl #(
        .CLK_FREQ (50_000_000),
        .BASE_CNT (BASE_CNT),
        .NUM_LED  (NUM_LED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode_next (mode_next),
        .speed     (speed),
        .led       (led),
        .mode      (mode),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_led();
        case (m_mode)
            1, 2:    return 1 << m_pos;
            3:       return m_on ? (1 << NUM_LED) - 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Entering a mode sets its starting pattern.
    function automatic void model_enter(input int nm);
        m_mode = nm;
        m_pos  = (nm == 2) ? NUM_LED - 1 : 0;
        m_on   = 1'b1;
    endfunction

    function automatic void model_edge(input bit r, input bit e, input bit mn, input int spd);
        int term;
        term = ((BASE_CNT + 1) << spd) - 1;
        m_tick = 1'b0;
        if (!r) begin
            m_cnt = 0;
            model_enter(0);
        end else if (mn) begin
            model_enter((m_mode + 1) % 4);
            m_cnt = 0;
        end else if (e) begin
            if (m_cnt >= term) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                if (m_mode == 1) m_pos = (m_pos + 1) % NUM_LED;
                else if (m_mode == 2) m_pos = (m_pos + NUM_LED - 1) % NUM_LED;
                else if (m_mode == 3) m_on = ~m_on;
            end else begin
                m_cnt++;
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge(rst_n, en, mode_next, int'(speed));
        #1;
        check("led",  32'(led),  32'(exp_led()));
        check("mode", 32'(mode), 32'(m_mode));
        check("tick", 32'(tick), 32'(m_tick));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_next();
        mode_next = 1'b1;
        cycle();
        mode_next = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_cnt     = 0;
        m_mode    = 0;
        m_pos     = 0;
        m_on      = 1'b1;
        m_tick    = 1'b0;
        rst_n     = 1'b0;
        en        = 1'b0;
        mode_next = 1'b0;
        speed     = 2'd0;
        @(negedge clk);
        run(2);

        // reset while running left
        rst_n = 1'b1;
        en    = 1'b1;
        pulse_next();
        run(6);
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(10);

        // run left, fastest speed
        pulse_next();
        run(20);

        // run right at speed 2
        speed = 2'd2;
        pulse_next();
        run(70);

        // blink, then freeze and resume
        speed = 2'd0;
        pulse_next();
        run(10);
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(10);

        // speed drop from the slowest period while cnt sits above the new term
        speed = 2'd3;
        pulse_next();
        pulse_next();
        for (int i = 0; i < 100 && m_cnt != 20; i++) cycle();
        speed = 2'd0;
        cycle();
        check("speed_drop_tick", 32'(tick), 32'd1);
        run(12);

        // mode change coinciding with a step in run-left
        for (int i = 0; i < 20 && m_cnt != 3; i++) cycle();
        pulse_next();
        check("coincide_tick", 32'(tick), 32'd0);
        check("coincide_led",  32'(led),  32'h8);
        check("coincide_mode", 32'(mode), 32'd2);
        run(8);

        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            en        = ($urandom_range(0, 9) != 0);
            mode_next = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
